// File: rtl/gpio_bank.sv
// gpio_bank: N_PORTS x WIDTH GPIO on the J1 IO bus; synced inputs, atomic set/clr/tgl, edge irq.
// Latency: writes 1 clk, pin->IN SYNC_STAGES clks, irq 1 clk after PEND; no backpressure (always ready).
module gpio_bank #(
  parameter int N_PORTS     = 3,
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = $clog2(N_PORTS) + 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_sel,
  input  logic                     io_wr,
  input  logic                     io_rd,
  input  logic [ADDR_W-1:0]        io_addr,
  input  logic [15:0]              io_dout,
  output logic [15:0]              io_din,
  input  logic [N_PORTS*WIDTH-1:0] pin_in,
  output logic [N_PORTS*WIDTH-1:0] pin_out,
  output logic [N_PORTS*WIDTH-1:0] pin_oe,
  output logic                     irq
);
  localparam int NB      = N_PORTS * WIDTH;
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  typedef logic [WIDTH-1:0] word_t;

  word_t out_q     [N_PORTS];
  word_t out_d     [N_PORTS];
  word_t dir_q     [N_PORTS];
  word_t dir_d     [N_PORTS];
  word_t rise_en_q [N_PORTS];
  word_t rise_en_d [N_PORTS];
  word_t fall_en_q [N_PORTS];
  word_t fall_en_d [N_PORTS];
  word_t pend_q    [N_PORTS];
  word_t pend_d    [N_PORTS];

  logic [NB-1:0]    sync_q [SYNC_STAGES];
  logic [NB-1:0]    sync_d [SYNC_STAGES];
  logic [NB-1:0]    prev_q, prev_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic             irq_q, irq_d;

  logic [NB-1:0]     in_w;
  logic [ADDR_W-1:0] port_idx;
  logic [3:0]        reg_idx;
  logic              wr_en;
  logic              armed;
  word_t             wdat;
  word_t             rdata;
  logic              unused_ok;

  assign in_w      = sync_q[SYNC_STAGES-1];
  assign port_idx  = io_addr >> 4;
  assign reg_idx   = io_addr[3:0];
  assign wr_en     = io_sel & io_wr;
  assign wdat      = io_dout[WIDTH-1:0];
  assign armed     = (arm_q == ARM_W'(ARM_MAX));
  assign unused_ok = io_rd ^ (^io_dout);

  always_comb begin
    word_t in_p, prev_p, edge_p, w1c;
    logic  pend_any;
    in_p     = '0;
    prev_p   = '0;
    edge_p   = '0;
    w1c      = '0;
    pend_any = 1'b0;
    sync_d[0] = pin_in;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    prev_d = in_w;
    arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
    for (int p = 0; p < N_PORTS; p++) begin
      out_d[p]     = out_q[p];
      dir_d[p]     = dir_q[p];
      rise_en_d[p] = rise_en_q[p];
      fall_en_d[p] = fall_en_q[p];
      in_p   = in_w[p*WIDTH +: WIDTH];
      prev_p = prev_q[p*WIDTH +: WIDTH];
      // Gate edges until the sync chain has flushed its post-reset zeros.
      edge_p = '0;
      if (armed)
        edge_p = (in_p & ~prev_p & rise_en_q[p]) | (~in_p & prev_p & fall_en_q[p]);
      w1c = '0;
      if (wr_en && port_idx == ADDR_W'(p)) begin
        case (reg_idx)
          4'd1:    out_d[p]     = wdat;
          4'd2:    dir_d[p]     = wdat;
          4'd3:    out_d[p]     = out_q[p] | wdat;
          4'd4:    out_d[p]     = out_q[p] & ~wdat;
          4'd5:    out_d[p]     = out_q[p] ^ wdat;
          4'd6:    rise_en_d[p] = wdat;
          4'd7:    fall_en_d[p] = wdat;
          4'd8:    w1c          = wdat;
          default: ;
        endcase
      end
      pend_d[p] = (pend_q[p] & ~w1c) | edge_p;
      pend_any  = pend_any | (|pend_q[p]);
    end
    irq_d = pend_any;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '{default: '0};
      dir_q     <= '{default: '0};
      rise_en_q <= '{default: '0};
      fall_en_q <= '{default: '0};
      pend_q    <= '{default: '0};
      sync_q    <= '{default: '0};
      prev_q    <= '0;
      arm_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      arm_q     <= arm_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (port_idx == ADDR_W'(p)) begin
        case (reg_idx)
          4'd0:    rdata = in_w[p*WIDTH +: WIDTH];
          4'd1:    rdata = out_q[p];
          4'd2:    rdata = dir_q[p];
          4'd6:    rdata = rise_en_q[p];
          4'd7:    rdata = fall_en_q[p];
          4'd8:    rdata = pend_q[p];
          default: rdata = '0;
        endcase
      end
    end
  end

  assign io_din = io_sel ? 16'(rdata) : 16'h0000;

  always_comb begin
    pin_out = '0;
    pin_oe  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      pin_out[p*WIDTH +: WIDTH] = out_q[p];
      pin_oe[p*WIDTH +: WIDTH]  = dir_q[p];
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank with a cycle-level reference model checked every cycle.
module tb_gpio_bank;
  localparam int NP = 3;
  localparam int W  = 16;
  localparam int SS = 2;
  localparam int AW = 6;
  localparam int NB = NP * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_sel, io_wr, io_rd;
  logic [AW-1:0] io_addr;
  logic [15:0]   io_dout;
  logic [15:0]   io_din;
  logic [NB-1:0] pin_in, pin_out, pin_oe;
  logic          irq;

  int checks = 0;
  int errors = 0;

  gpio_bank #(.N_PORTS(NP), .WIDTH(W), .SYNC_STAGES(SS), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .io_sel(io_sel), .io_wr(io_wr), .io_rd(io_rd),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: IN is the pin value seen SS clocks ago, everything else
  // follows the register-map rules directly.
  logic [15:0]   m_out [NP];
  logic [15:0]   m_dir [NP];
  logic [15:0]   m_re  [NP];
  logic [15:0]   m_fe  [NP];
  logic [15:0]   m_pend[NP];
  logic          m_irq;
  logic [NB-1:0] m_prev;
  logic [NB-1:0] pin_hist[$];
  int            m_cyc;
  bit            started = 0;

  function automatic logic [NB-1:0] m_in();
    return (pin_hist.size() == SS) ? pin_hist[0] : '0;
  endfunction

  always @(posedge clk) begin
    logic [NB-1:0] in_now;
    logic [15:0]   iw, pw, rise, fall, w1c;
    logic          any;
    started = 1;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        m_out[p] = 0; m_dir[p] = 0; m_re[p] = 0; m_fe[p] = 0; m_pend[p] = 0;
      end
      m_irq = 0; m_prev = '0; m_cyc = 0;
      pin_hist.delete();
    end else begin
      in_now = m_in();
      any = 0;
      for (int p = 0; p < NP; p++) if (m_pend[p] != 0) any = 1;
      for (int p = 0; p < NP; p++) begin
        iw = in_now[p*W +: W];
        pw = m_prev[p*W +: W];
        rise = iw & ~pw & m_re[p];
        fall = ~iw & pw & m_fe[p];
        if (m_cyc < SS + 1) begin rise = 0; fall = 0; end
        w1c = 0;
        if (io_sel && io_wr && int'(io_addr) / 16 == p) begin
          case (int'(io_addr) % 16)
            1: m_out[p] = io_dout;
            2: m_dir[p] = io_dout;
            3: m_out[p] = m_out[p] | io_dout;
            4: m_out[p] = m_out[p] & ~io_dout;
            5: m_out[p] = m_out[p] ^ io_dout;
            6: m_re[p]  = io_dout;
            7: m_fe[p]  = io_dout;
            8: w1c      = io_dout;
            default: ;
          endcase
        end
        m_pend[p] = (m_pend[p] & ~w1c) | rise | fall;
      end
      m_irq  = any;
      m_prev = in_now;
      pin_hist.push_back(pin_in);
      if (pin_hist.size() > SS) void'(pin_hist.pop_front());
      if (m_cyc < SS + 1) m_cyc++;
    end
  end

  function automatic logic [15:0] exp_din();
    int p, r;
    logic [NB-1:0] in_now;
    if (!io_sel) return 16'h0;
    p = int'(io_addr) / 16;
    r = int'(io_addr) % 16;
    if (p >= NP) return 16'h0;
    in_now = m_in();
    case (r)
      0: return in_now[p*W +: W];
      1: return m_out[p];
      2: return m_dir[p];
      6: return m_re[p];
      7: return m_fe[p];
      8: return m_pend[p];
      default: return 16'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [NB-1:0] eo, ed;
    if (started) begin
      for (int p = 0; p < NP; p++) begin
        eo[p*W +: W] = m_out[p];
        ed[p*W +: W] = m_dir[p];
      end
      chk("model pin_out", 64'(pin_out), 64'(eo));
      chk("model pin_oe", 64'(pin_oe), 64'(ed));
      chk("model irq", 64'(irq), 64'(m_irq));
      chk("model io_din", 64'(io_din), 64'(exp_din()));
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    io_sel = 1; io_wr = 1; io_addr = a; io_dout = d;
    @(posedge clk); #1;
    io_sel = 0; io_wr = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [15:0] e, input string name);
    io_sel = 1; io_rd = 1; io_addr = a;
    @(negedge clk);
    chk(name, 64'(io_din), 64'(e));
    @(posedge clk); #1;
    io_sel = 0; io_rd = 0;
  endtask

  initial begin
    reset = 1; io_sel = 0; io_wr = 0; io_rd = 0; io_addr = '0; io_dout = '0;
    pin_in = '1;
    @(posedge clk);
    @(negedge clk);
    chk("reset pin_oe", 64'(pin_oe), 64'h0);
    chk("reset pin_out", 64'(pin_out), 64'h0);
    chk("reset irq", 64'(irq), 64'h0);
    @(posedge clk);
    @(posedge clk); #1;
    // Enable rising edges on port0 in the very first post-reset cycle.
    reset = 0; io_sel = 1; io_wr = 1; io_addr = 6'h06; io_dout = 16'hFFFF;
    @(posedge clk); #1;
    io_sel = 0; io_wr = 0;
    repeat (SS + 1) @(posedge clk);
    #1;
    rd(6'h00, 16'hFFFF, "p0 IN after reset");
    rd(6'h08, 16'h0000, "p0 PEND armed gate");
    chk("irq after arm", 64'(irq), 64'h0);
    wr(6'h06, 16'h0000);

    // Atomic ops on port 1.
    wr(6'h11, 16'h00F0); rd(6'h11, 16'h00F0, "OUT write");
    chk("pin_out p1 write", 64'(pin_out[31:16]), 64'h00F0);
    wr(6'h13, 16'h000F); rd(6'h11, 16'h00FF, "OUT set");
    chk("pin_out p1 set", 64'(pin_out[31:16]), 64'h00FF);
    wr(6'h14, 16'h0030); rd(6'h11, 16'h00CF, "OUT clr");
    chk("pin_out p1 clr", 64'(pin_out[31:16]), 64'h00CF);
    wr(6'h15, 16'h8001); rd(6'h11, 16'h80CE, "OUT tgl");
    chk("pin_out p1 tgl", 64'(pin_out[31:16]), 64'h80CE);
    rd(6'h13, 16'h0000, "SET reads 0");
    wr(6'h12, 16'hFFFF);
    chk("pin_oe p1", 64'(pin_oe), 64'h0000_FFFF_0000);

    // Sync latency on port0 bit0.
    pin_in[0] = 0;
    repeat (4) @(posedge clk);
    #1;
    pin_in[0] = 1; io_sel = 1; io_addr = 6'h00;
    @(negedge clk); chk("sync T+0", 64'(io_din[0]), 64'h0);
    @(negedge clk); chk("sync T+1", 64'(io_din[0]), 64'h0);
    @(negedge clk); chk("sync T+2", 64'(io_din[0]), 64'h1);
    @(posedge clk); #1; io_sel = 0;

    // Edge detect and irq on port2 bit2 (pin 34).
    pin_in[34] = 0;
    repeat (4) @(posedge clk);
    #1;
    wr(6'h26, 16'h0004);
    wr(6'h27, 16'h0004);
    pin_in[34] = 1; io_sel = 1; io_addr = 6'h28;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("pend rise+2", 64'(io_din), 64'h0);
    @(negedge clk); chk("pend rise+3", 64'(io_din), 64'h4);
    chk("irq rise+3", 64'(irq), 64'h0);
    @(negedge clk); chk("irq rise+4", 64'(irq), 64'h1);
    @(posedge clk); #1; io_sel = 0;
    wr(6'h28, 16'h0004);
    @(negedge clk); chk("irq w1c+1", 64'(irq), 64'h1);
    @(negedge clk); chk("irq w1c+2", 64'(irq), 64'h0);
    @(posedge clk);
    @(posedge clk); #1;
    pin_in[34] = 0; io_sel = 1; io_addr = 6'h28;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("pend fall+2", 64'(io_din), 64'h0);
    @(negedge clk); chk("pend fall+3", 64'(io_din), 64'h4);
    @(negedge clk); chk("irq fall+4", 64'(irq), 64'h1);
    @(posedge clk); #1; io_sel = 0;

    // W1C of bit0 in the same cycle a new rising edge on bit0 is detected.
    wr(6'h28, 16'h0004);
    wr(6'h26, 16'h0005);
    pin_in[32] = 0;
    repeat (4) @(posedge clk);
    #1;
    pin_in[32] = 1;
    repeat (5) @(posedge clk);
    #1;
    rd(6'h28, 16'h0001, "pend first rise");
    chk("irq first rise", 64'(irq), 64'h1);
    pin_in[32] = 0;
    repeat (4) @(posedge clk);
    #1;
    pin_in[32] = 1;
    @(posedge clk);
    wr(6'h28, 16'h0001);
    chk("irq edge vs w1c", 64'(irq), 64'h1);
    rd(6'h28, 16'h0001, "pend edge wins");
    chk("irq after edge wins", 64'(irq), 64'h1);

    // Out-of-range port and reserved register.
    wr(6'h31, 16'h1234);
    wr(6'h0C, 16'h1234);
    rd(6'h31, 16'h0000, "port3 OUT reads 0");
    rd(6'h0C, 16'h0000, "reserved reads 0");
    chk("pin_out unchanged", 64'(pin_out), 64'h0000_80CE_0000);
    chk("pin_oe unchanged", 64'(pin_oe), 64'h0000_FFFF_0000);
    io_sel = 0; io_addr = 6'h11;
    @(negedge clk); chk("io_sel=0 din", 64'(io_din), 64'h0);

    // Mid-operation reset with a write presented during it.
    @(posedge clk); #1;
    reset = 1; io_sel = 1; io_wr = 1; io_addr = 6'h11; io_dout = 16'hFFFF;
    @(posedge clk); #1;
    reset = 0; io_sel = 0; io_wr = 0;
    chk("mid reset pin_out", 64'(pin_out), 64'h0);
    chk("mid reset pin_oe", 64'(pin_oe), 64'h0);
    chk("mid reset irq", 64'(irq), 64'h0);
    rd(6'h11, 16'h0000, "write in reset ignored");
    repeat (6) @(posedge clk);
    #1;
    rd(6'h28, 16'h0000, "pend after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
